// File: rtl/clk_div_pkg.sv
// rtl/clk_div_pkg.sv - shared defaults and helpers for the multi-channel clock divider
package clk_div_pkg;

    localparam int CDIV_RATIO_WD  = 8;
    localparam int CDIV_DEF_RATIO = 2;
    localparam int CDIV_MAX_WD    = 16;

    // Length of the high phase; one extra bit so R+1 cannot wrap at the maximum ratio.
    function automatic logic [CDIV_MAX_WD:0] hi_len(input logic [CDIV_MAX_WD-1:0] r);
        logic [CDIV_MAX_WD:0] t;
        t = {1'b0, r} + {{CDIV_MAX_WD{1'b0}}, 1'b1};
        return t >> 1;
    endfunction

endpackage

// File: rtl/clk_div_multi_if.sv
// rtl/clk_div_multi_if.sv - control and output bundle of the multi-channel clock divider
interface clk_div_multi_if
    import clk_div_pkg::*;
#(
    parameter int NUM_CH   = 4,
    parameter int RATIO_WD = CDIV_RATIO_WD
);
    logic [NUM_CH-1:0]          clk_en;
    logic [NUM_CH*RATIO_WD-1:0] div_ratio;
    logic [NUM_CH-1:0]          ratio_load;
    logic                       sync;
    logic [NUM_CH-1:0]          ratio_ack;
    logic [NUM_CH-1:0]          div_clk;
    logic [NUM_CH-1:0]          tick;

    modport master (
        output clk_en, div_ratio, ratio_load, sync,
        input  ratio_ack, div_clk, tick
    );

    modport slave (
        input  clk_en, div_ratio, ratio_load, sync,
        output ratio_ack, div_clk, tick
    );
endinterface

// File: rtl/clk_div_chan.sv
// rtl/clk_div_chan.sv - one divider channel: counter, shadowed ratio, tick, ack and bypass mux
module clk_div_chan
    import clk_div_pkg::*;
#(
    parameter int RATIO_WD  = CDIV_RATIO_WD,
    parameter int DEF_RATIO = CDIV_DEF_RATIO
) (
    input  logic                I_ref_clk,
    input  logic                I_rst,
    input  logic                clk_en,
    input  logic [RATIO_WD-1:0] div_ratio,
    input  logic                ratio_load,
    input  logic                sync,
    output logic                ratio_ack,
    output logic                div_clk,
    output logic                tick
);
    localparam logic [RATIO_WD-1:0] ONE = RATIO_WD'(1);
    localparam logic [RATIO_WD-1:0] TWO = RATIO_WD'(2);

    logic [RATIO_WD-1:0] r_q, r_nx, shadow_q, shadow_nx, cnt_q, cnt_nx, cnt_inc;
    logic                pend_q, pend_nx, div_q, div_nx, tick_q, tick_nx;
    logic                ack_q, byp_q, byp_nx, run_q;
    logic                running, wrap, apply, upd;
    logic [CDIV_MAX_WD:0] hi_nx;

    always_comb begin
        running   = clk_en && (r_q >= TWO);
        wrap      = (cnt_q == r_q - ONE);
        // Stopped/bypass channels accept a new ratio on any edge; running ones only at a boundary.
        apply     = !running || sync || (run_q && wrap);
        upd       = apply && (ratio_load || pend_q);
        r_nx      = upd ? (ratio_load ? div_ratio : shadow_q) : r_q;
        shadow_nx = shadow_q;
        pend_nx   = pend_q;
        if (apply) begin
            pend_nx = 1'b0;
        end else if (ratio_load) begin
            shadow_nx = div_ratio;
            pend_nx   = 1'b1;
        end
        hi_nx   = hi_len(CDIV_MAX_WD'(r_nx));
        cnt_inc = wrap ? '0 : cnt_q + ONE;
        cnt_nx  = '0;
        div_nx  = 1'b0;
        tick_nx = 1'b0;
        if (running) begin
            if (!run_q || sync) begin
                div_nx  = 1'b1;
                tick_nx = 1'b1;
            end else begin
                cnt_nx  = cnt_inc;
                div_nx  = ((CDIV_MAX_WD+1)'(cnt_inc) < hi_nx);
                tick_nx = (cnt_inc == '0);
            end
        end
        byp_nx = clk_en && (r_nx < TWO);
    end

    always_ff @(posedge I_ref_clk) begin
        if (I_rst) begin
            r_q      <= RATIO_WD'(DEF_RATIO);
            shadow_q <= '0;
            pend_q   <= 1'b0;
            cnt_q    <= '0;
            div_q    <= 1'b0;
            tick_q   <= 1'b0;
            ack_q    <= 1'b0;
            byp_q    <= 1'b0;
            run_q    <= 1'b0;
        end else begin
            r_q      <= r_nx;
            shadow_q <= shadow_nx;
            pend_q   <= pend_nx;
            cnt_q    <= cnt_nx;
            div_q    <= div_nx;
            tick_q   <= tick_nx;
            ack_q    <= upd;
            byp_q    <= byp_nx;
            run_q    <= running;
        end
    end

    assign ratio_ack = ack_q;
    assign div_clk   = byp_q ? I_ref_clk : div_q;
    assign tick      = byp_q | tick_q;
endmodule

// File: rtl/clk_div_multi.sv
// rtl/clk_div_multi.sv - NUM_CH independent programmable dividers sharing one reference clock
module clk_div_multi
    import clk_div_pkg::*;
#(
    parameter int NUM_CH    = 4,
    parameter int RATIO_WD  = CDIV_RATIO_WD,
    parameter int DEF_RATIO = CDIV_DEF_RATIO
) (
    input  logic            I_ref_clk,
    input  logic            I_rst,
    clk_div_multi_if.slave  bus
);
    logic [NUM_CH-1:0] ack_w, div_w, tick_w;

    for (genvar k = 0; k < NUM_CH; k++) begin : g_chan
        clk_div_chan #(
            .RATIO_WD  (RATIO_WD),
            .DEF_RATIO (DEF_RATIO)
        ) u_chan (
            .I_ref_clk  (I_ref_clk),
            .I_rst      (I_rst),
            .clk_en     (bus.clk_en[k]),
            .div_ratio  (bus.div_ratio[k*RATIO_WD +: RATIO_WD]),
            .ratio_load (bus.ratio_load[k]),
            .sync       (bus.sync),
            .ratio_ack  (ack_w[k]),
            .div_clk    (div_w[k]),
            .tick       (tick_w[k])
        );
    end

    assign bus.ratio_ack = ack_w;
    assign bus.div_clk   = div_w;
    assign bus.tick      = tick_w;
endmodule
